executor: RTL and testbench
===========================

EXECUTOR -- requirements
Module: executor

Interface
REQ-001 Ports SHALL be: clk  in  1  sole clock, rising edge.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 start_i  in  1  one-cycle pulse from matcher ready_o; lookup result valid.
REQ-004 is_match_i  in  1  matcher hit flag, sampled with start_i.
REQ-005 flow_val_i  in  BYTE_BUS x MAX_VAL_LEN  matcher action bytes, sampled with start_i.
REQ-006 pkt_hdr_i  in  BYTE_BUS x HDR_MAX_LEN  packet header bytes, sampled with start_i.
REQ-007 parsed_hdrs_i  in  DATA_BUS x NUM_HEADERS  header start offsets, sampled with start_i.
REQ-008 mod_start_i, mod_default_port_i[7:0], mod_miss_drop_i  in  reconfiguration strobe plus miss-default values.
REQ-009 ready_o  out  1  one-cycle completion pulse.
REQ-010 pkt_hdr_o  out  BYTE_BUS x HDR_MAX_LEN  modified header, valid from ready_o until next accepted start_i.
REQ-011 drop_o / egress_port_o[7:0] / error_o  out  verdict, port, out-of-range flag, valid with pkt_hdr_o.
REQ-012 busy_o  out  1  high in any state other than IDLE.

Function
REQ-013 Action layout SHALL be: byte0 opcode, byte1 hdr id (low 4 bits) or port, byte2 field offset, byte3 length, byte4 onward data.
REQ-014 Opcodes SHALL be: 0 FORWARD, 1 SET_FIELD, 2 DROP, 3 SET_PORT; all other values SHALL behave as FORWARD and set error_o.
REQ-015 FSM states SHALL be IDLE, DECODE, WRITE, DONE.
REQ-016 IDLE: mod_start_i SHALL latch the default registers; else start_i SHALL latch all inputs, clear verdict outputs and go to DECODE; mod_start_i wins if both are asserted.
REQ-017 DECODE on a miss SHALL set drop_o=mod_miss_drop, egress_port_o=default port, then go to DONE.
REQ-018 DECODE on a hit SHALL behave as follows:
- FORWARD: verdict port = default port, go to DONE.
- DROP: drop_o=1, go to DONE.
- SET_PORT: egress_port_o=byte1, go to DONE.
- SET_FIELD: base = parsed_hdrs[id] + offset, byte counter = 0, go to WRITE.
REQ-019 WRITE SHALL write one data byte per cycle to pkt_hdr_o[base+cnt] and increment cnt; when cnt reaches len, go to DONE.
REQ-020 len SHALL be clamped to MAX_VAL_LEN-4; len=0 SHALL go directly to DONE with the header unchanged.
REQ-021 When base+cnt >= HDR_MAX_LEN, that byte SHALL be skipped and error_o set; egress_port_o SHALL be the default port.
REQ-022 DONE SHALL pulse ready_o for 1 cycle and return to IDLE.
REQ-023 Latency from start_i to ready_o SHALL be 3 cycles for non-SET_FIELD actions and 3+len cycles for SET_FIELD.
REQ-024 start_i while busy_o=1 SHALL be ignored; mod_start_i outside IDLE SHALL be ignored.
REQ-025 Address arithmetic SHALL be DATA_BUS wide with no wrap; out-of-range handling SHALL follow REQ-021.

Reset
REQ-026 rst SHALL asynchronously force IDLE and clear all outputs, pkt_hdr_o and the latches to 0; default port and miss-drop registers SHALL reset to 0.
REQ-027 rst asserted mid-WRITE SHALL abort the action with no ready_o pulse.
REQ-028 The first start_i after rst deasserts SHALL be honoured.

Configuration
REQ-029 With EXECUTOR_STATS_EN defined, the block SHALL add hit_cnt_o, miss_cnt_o and drop_cnt_o outputs (32 bits each, wrapping) that increment in DONE and reset to 0.
REQ-030 Without EXECUTOR_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 Opcode constants and the action byte-index constants SHALL live in def.svh alongside BYTE_BUS, DATA_BUS, HDR_MAX_LEN, MAX_VAL_LEN and NUM_HEADERS.
REQ-032 The block SHALL be a single module with no sub-module; the FSM is small enough to stay inline.

Verification
REQ-033 Miss with mod_miss_drop=1, default port 5: ready_o 3 cycles after start_i, drop_o=1, egress_port_o=5, header unchanged.
REQ-034 Hit SET_FIELD with parsed_hdrs[1]=14, offset 2, len 4, data AA BB CC DD: bytes 16..19 = AA..DD, ready_o at cycle 7, error_o=0.
REQ-035 Hit SET_FIELD with base HDR_MAX_LEN-2, len 4: last 2 header bytes written, error_o=1, no out-of-bounds write.
REQ-036 Hit SET_PORT byte1=9: egress_port_o=9; second start_i during busy is ignored; opcode 7 gives FORWARD with error_o=1.
REQ-037 rst pulse mid-WRITE: all outputs 0, no ready_o, next start_i processed normally.
REQ-038 With EXECUTOR_STATS_EN: 2 hits, 1 miss, 1 drop give hit_cnt_o=2, miss_cnt_o=1, drop_cnt_o=1.

Source files
------------

// File: rtl/executor_pkg.sv
// Shared widths, action-layout constants and bus types for the flow-action executor.
package executor_pkg;

    localparam int unsigned BYTE_BUS     = 8;
    localparam int unsigned DATA_BUS     = 8;
    localparam int unsigned HDR_MAX_LEN  = 32;
    localparam int unsigned MAX_VAL_LEN  = 16;
    localparam int unsigned NUM_HEADERS  = 16;

    localparam int unsigned MAX_DATA_LEN = MAX_VAL_LEN - 4;
    localparam int unsigned LEN_W        = $clog2(MAX_VAL_LEN);
    localparam int unsigned HDR_IDX_W    = $clog2(HDR_MAX_LEN);
    localparam int unsigned ID_W         = $clog2(NUM_HEADERS);
    // Two extra bits so header start + field offset + byte count never wraps.
    localparam int unsigned ADDR_W       = DATA_BUS + 2;

    // Action byte indices.
    localparam int unsigned IDX_OPCODE   = 0;
    localparam int unsigned IDX_ID       = 1;
    localparam int unsigned IDX_OFFSET   = 2;
    localparam int unsigned IDX_LEN      = 3;
    localparam int unsigned IDX_DATA     = 4;

    typedef logic [BYTE_BUS-1:0]                   byte_t;
    typedef byte_t [MAX_VAL_LEN-1:0]               flow_val_t;
    typedef byte_t [HDR_MAX_LEN-1:0]               hdr_t;
    typedef logic [NUM_HEADERS-1:0][DATA_BUS-1:0]  parsed_t;

    localparam byte_t OP_FORWARD   = 8'd0;
    localparam byte_t OP_SET_FIELD = 8'd1;
    localparam byte_t OP_DROP      = 8'd2;
    localparam byte_t OP_SET_PORT  = 8'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input byte_t len);
        if (len > BYTE_BUS'(MAX_DATA_LEN)) return LEN_W'(MAX_DATA_LEN);
        return LEN_W'(len);
    endfunction

endpackage

// File: rtl/executor.sv
// Flow-action executor: applies a matcher's action (forward/drop/set port/rewrite bytes) to a header.
// Optional EXECUTOR_STATS_EN adds wrapping hit/miss/drop counters.
module executor
    import executor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        is_match_i,
    input  flow_val_t   flow_val_i,
    input  hdr_t        pkt_hdr_i,
    input  parsed_t     parsed_hdrs_i,
    input  logic        mod_start_i,
    input  logic [7:0]  mod_default_port_i,
    input  logic        mod_miss_drop_i,
    output logic        ready_o,
    output hdr_t        pkt_hdr_o,
    output logic        drop_o,
    output logic [7:0]  egress_port_o,
    output logic        error_o,
`ifdef EXECUTOR_STATS_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
    output logic [31:0] drop_cnt_o,
`endif
    output logic        busy_o
);

    state_e            state;
    flow_val_t         flow_val_q;
    parsed_t           parsed_q;
    logic              is_match_q;
    logic [7:0]        default_port_q;
    logic              miss_drop_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  len_q;

    byte_t             opcode_c;
    logic [ID_W-1:0]   hdr_id_c;
    logic [ADDR_W-1:0] base_c;
    logic [ADDR_W-1:0] addr_c;
    logic              in_range_c;
    logic [LEN_W-1:0]  data_idx_c;
    logic [LEN_W-1:0]  len_c;

    // Action decode and write-address generation from the latched lookup result.
    always_comb begin
        opcode_c   = flow_val_q[IDX_OPCODE];
        hdr_id_c   = flow_val_q[IDX_ID][ID_W-1:0];
        len_c      = clamp_len(flow_val_q[IDX_LEN]);
        base_c     = ADDR_W'(parsed_q[hdr_id_c]) + ADDR_W'(flow_val_q[IDX_OFFSET]);
        addr_c     = base_q + ADDR_W'(cnt_q);
        in_range_c = addr_c < ADDR_W'(HDR_MAX_LEN);
        data_idx_c = LEN_W'(IDX_DATA) + cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            flow_val_q     <= '0;
            parsed_q       <= '0;
            is_match_q     <= 1'b0;
            default_port_q <= '0;
            miss_drop_q    <= 1'b0;
            base_q         <= '0;
            cnt_q          <= '0;
            len_q          <= '0;
            ready_o        <= 1'b0;
            pkt_hdr_o      <= '0;
            drop_o         <= 1'b0;
            egress_port_o  <= '0;
            error_o        <= 1'b0;
            busy_o         <= 1'b0;
`ifdef EXECUTOR_STATS_EN
            hit_cnt_o      <= '0;
            miss_cnt_o     <= '0;
            drop_cnt_o     <= '0;
`endif
        end else begin
            ready_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mod_start_i) begin
                        default_port_q <= mod_default_port_i;
                        miss_drop_q    <= mod_miss_drop_i;
                    end else if (start_i) begin
                        flow_val_q    <= flow_val_i;
                        parsed_q      <= parsed_hdrs_i;
                        is_match_q    <= is_match_i;
                        pkt_hdr_o     <= pkt_hdr_i;
                        drop_o        <= 1'b0;
                        egress_port_o <= '0;
                        error_o       <= 1'b0;
                        busy_o        <= 1'b1;
                        state         <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state <= S_DONE;
                    if (!is_match_q) begin
                        drop_o        <= miss_drop_q;
                        egress_port_o <= default_port_q;
                    end else begin
                        case (opcode_c)
                            OP_FORWARD:  egress_port_o <= default_port_q;
                            OP_DROP:     drop_o        <= 1'b1;
                            OP_SET_PORT: egress_port_o <= flow_val_q[IDX_ID];
                            OP_SET_FIELD: begin
                                egress_port_o <= default_port_q;
                                base_q        <= base_c;
                                cnt_q         <= '0;
                                len_q         <= len_c;
                                if (len_c != '0) state <= S_WRITE;
                            end
                            default: begin
                                egress_port_o <= default_port_q;
                                error_o       <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    // Bytes past the end of the header are dropped and flagged.
                    if (in_range_c) pkt_hdr_o[addr_c[HDR_IDX_W-1:0]] <= flow_val_q[data_idx_c];
                    else            error_o <= 1'b1;
                    cnt_q <= cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q) state <= S_DONE;
                end
                S_DONE: begin
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    state   <= S_IDLE;
`ifdef EXECUTOR_STATS_EN
                    if (is_match_q) hit_cnt_o  <= hit_cnt_o + 32'd1;
                    else            miss_cnt_o <= miss_cnt_o + 32'd1;
                    if (drop_o)     drop_cnt_o <= drop_cnt_o + 32'd1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_executor.sv
// Self-checking bench for executor: directed corner cases plus random actions against a reference model.
module tb_executor;
    import executor_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        is_match_i = 1'b0;
    flow_val_t   flow_val_i = '0;
    hdr_t        pkt_hdr_i = '0;
    parsed_t     parsed_hdrs_i = '0;
    logic        mod_start_i = 1'b0;
    logic [7:0]  mod_default_port_i = '0;
    logic        mod_miss_drop_i = 1'b0;
    logic        ready_o;
    hdr_t        pkt_hdr_o;
    logic        drop_o;
    logic [7:0]  egress_port_o;
    logic        error_o;
    logic        busy_o;
`ifdef EXECUTOR_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o, drop_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    // Reference state: configured defaults and expected statistics.
    logic [7:0] m_def_port = '0;
    logic       m_miss_drop = 1'b0;
    int         m_hit = 0, m_miss = 0, m_drop = 0;

    executor dut (
        .clk(clk), .rst(rst), .start_i(start_i), .is_match_i(is_match_i),
        .flow_val_i(flow_val_i), .pkt_hdr_i(pkt_hdr_i), .parsed_hdrs_i(parsed_hdrs_i),
        .mod_start_i(mod_start_i), .mod_default_port_i(mod_default_port_i),
        .mod_miss_drop_i(mod_miss_drop_i), .ready_o(ready_o), .pkt_hdr_o(pkt_hdr_o),
        .drop_o(drop_o), .egress_port_o(egress_port_o), .error_o(error_o),
`ifdef EXECUTOR_STATS_EN
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .drop_cnt_o(drop_cnt_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: verdict, rewritten header and latency straight from the action rules.
    function automatic void model(input logic m, input flow_val_t fv, input hdr_t h, input parsed_t ph,
                                  output hdr_t eh, output logic ed, output logic [7:0] ep,
                                  output logic ee, output int el);
        int op, n, base, a;
        eh = h; ed = 1'b0; ep = 8'd0; ee = 1'b0; el = 3;
        if (!m) begin
            ed = m_miss_drop;
            ep = m_def_port;
        end else begin
            op = int'(fv[0]);
            if (op == 0) ep = m_def_port;
            else if (op == 2) ed = 1'b1;
            else if (op == 3) ep = fv[1];
            else if (op == 1) begin
                ep = m_def_port;
                n = (int'(fv[3]) > 12) ? 12 : int'(fv[3]);
                base = int'(ph[int'(fv[1]) % 16]) + int'(fv[2]);
                for (int k = 0; k < n; k++) begin
                    a = base + k;
                    if (a < 32) eh[a] = fv[4 + k];
                    else ee = 1'b1;
                end
                el = 3 + n;
            end else begin
                ep = m_def_port;
                ee = 1'b1;
            end
        end
    endfunction

    task automatic configure(input logic [7:0] port, input logic md);
        @(negedge clk);
        mod_start_i = 1'b1; mod_default_port_i = port; mod_miss_drop_i = md;
        @(negedge clk);
        mod_start_i = 1'b0;
        m_def_port = port; m_miss_drop = md;
    endtask

    task automatic run_txn(input string tag, input logic m, input flow_val_t fv, input hdr_t h,
                           input parsed_t ph, input logic inject);
        hdr_t eh; logic ed, ee; logic [7:0] ep; int el, lat, extra;
        model(m, fv, h, ph, eh, ed, ep, ee, el);
        @(negedge clk);
        start_i = 1'b1; is_match_i = m; flow_val_i = fv; pkt_hdr_i = h; parsed_hdrs_i = ph;
        @(negedge clk);
        lat = 1;
        start_i = inject;
        if (inject) begin
            is_match_i = ~m; flow_val_i = ~fv; pkt_hdr_i = ~h;
        end
        while (ready_o !== 1'b1 && lat < 200) begin
            @(negedge clk);
            start_i = 1'b0;
            lat++;
        end
        start_i = 1'b0;
        check({tag, "_latency"}, 256'(lat), 256'(el));
        check({tag, "_drop"}, 256'(drop_o), 256'(ed));
        check({tag, "_port"}, 256'(egress_port_o), 256'(ep));
        check({tag, "_error"}, 256'(error_o), 256'(ee));
        check({tag, "_hdr"}, 256'(pkt_hdr_o), 256'(eh));
        check({tag, "_busy_done"}, 256'(busy_o), 256'(0));
        if (m) m_hit++; else m_miss++;
        if (ed) m_drop++;
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (ready_o === 1'b1 || busy_o === 1'b1) extra++;
            end
            check({tag, "_busy_start_ignored"}, 256'(extra), 256'(0));
        end
    endtask

    function automatic flow_val_t rand_fv();
        flow_val_t fv;
        int sel;
        for (int i = 0; i < 16; i++) fv[i] = 8'($urandom);
        sel = int'($urandom_range(0, 4));
        fv[0] = (sel == 4) ? 8'($urandom_range(4, 255)) : 8'(sel);
        fv[2] = 8'($urandom_range(0, 12));
        fv[3] = 8'($urandom_range(0, 15));
        return fv;
    endfunction

    initial begin
        flow_val_t fv;
        hdr_t      h;
        parsed_t   ph;
        int        cnt;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_ready", 256'(ready_o), 256'(0));
        check("reset_busy", 256'(busy_o), 256'(0));
        check("reset_hdr", 256'(pkt_hdr_o), 256'(0));
        check("reset_port", 256'({drop_o, error_o, egress_port_o}), 256'(0));
        rst = 1'b0;

        for (int i = 0; i < 32; i++) h[i] = 8'(i + 8'h40);
        ph = '0;

        // Miss with drop default and port 5.
        configure(8'd5, 1'b1);
        fv = '0;
        run_txn("miss_drop", 1'b0, fv, h, ph, 1'b0);

        // SET_FIELD into header 1 at offset 2.
        ph[1] = 8'd14;
        fv = '0; fv[0] = OP_SET_FIELD; fv[1] = 8'd1; fv[2] = 8'd2; fv[3] = 8'd4;
        fv[4] = 8'hAA; fv[5] = 8'hBB; fv[6] = 8'hCC; fv[7] = 8'hDD;
        run_txn("set_field", 1'b1, fv, h, ph, 1'b0);

        // SET_FIELD straddling the end of the header.
        ph[0] = 8'(HDR_MAX_LEN - 2);
        fv[1] = 8'd0; fv[2] = 8'd0;
        run_txn("set_field_edge", 1'b1, fv, h, ph, 1'b0);

        // Base far beyond the header: no address wrap.
        ph[2] = 8'd250; fv[1] = 8'd2; fv[2] = 8'd250;
        run_txn("set_field_nowrap", 1'b1, fv, h, ph, 1'b0);

        // Zero length and over-long length.
        fv[1] = 8'd1; fv[2] = 8'd0; fv[3] = 8'd0;
        run_txn("set_field_len0", 1'b1, fv, h, ph, 1'b0);
        ph[1] = 8'd4; fv[3] = 8'd20;
        for (int i = 4; i < 16; i++) fv[i] = 8'(8'h10 + i);
        run_txn("set_field_clamp", 1'b1, fv, h, ph, 1'b0);

        // SET_PORT with a start_i during busy, then illegal opcode, drop, forward.
        fv = '0; fv[0] = OP_SET_PORT; fv[1] = 8'd9;
        run_txn("set_port", 1'b1, fv, h, ph, 1'b1);
        fv[0] = 8'd7;
        run_txn("bad_opcode", 1'b1, fv, h, ph, 1'b0);
        fv[0] = OP_DROP;
        run_txn("drop", 1'b1, fv, h, ph, 1'b0);
        fv[0] = OP_FORWARD;
        run_txn("forward", 1'b1, fv, h, ph, 1'b0);

        // Reconfiguration wins over a simultaneous start.
        @(negedge clk);
        mod_start_i = 1'b1; start_i = 1'b1; mod_default_port_i = 8'd7; mod_miss_drop_i = 1'b0;
        @(negedge clk);
        mod_start_i = 1'b0; start_i = 1'b0;
        m_def_port = 8'd7; m_miss_drop = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1 || busy_o === 1'b1) cnt++;
        end
        check("mod_wins_no_txn", 256'(cnt), 256'(0));
        run_txn("miss_after_mod", 1'b0, fv, h, ph, 1'b0);

        // Random actions.
        for (int t = 0; t < 40; t++) begin
            fv = rand_fv();
            for (int i = 0; i < 32; i++) h[i] = 8'($urandom);
            for (int i = 0; i < 16; i++) ph[i] = 8'($urandom_range(0, 34));
            if (t % 10 == 5) configure(8'($urandom), 1'($urandom));
            run_txn($sformatf("rand%0d", t), 1'($urandom_range(0, 3) != 0), fv, h, ph, (t % 7) == 3);
        end

`ifdef EXECUTOR_STATS_EN
        check("stat_hit", 256'(hit_cnt_o), 256'(m_hit));
        check("stat_miss", 256'(miss_cnt_o), 256'(m_miss));
        check("stat_drop", 256'(drop_cnt_o), 256'(m_drop));
`endif

        // Reset in the middle of a write.
        configure(8'd3, 1'b1);
        ph = '0; ph[0] = 8'd2;
        fv = '0; fv[0] = OP_SET_FIELD; fv[3] = 8'd8;
        for (int i = 4; i < 16; i++) fv[i] = 8'hE0 + 8'(i);
        @(negedge clk);
        start_i = 1'b1; is_match_i = 1'b1; flow_val_i = fv; pkt_hdr_i = h; parsed_hdrs_i = ph;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 256'(ready_o), 256'(0));
        check("rst_mid_busy", 256'(busy_o), 256'(0));
        check("rst_mid_hdr", 256'(pkt_hdr_o), 256'(0));
        check("rst_mid_verdict", 256'({drop_o, error_o, egress_port_o}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        m_def_port = '0; m_miss_drop = 1'b0; m_hit = 0; m_miss = 0; m_drop = 0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) cnt++;
        end
        check("rst_mid_no_ready", 256'(cnt), 256'(0));
        run_txn("post_rst_miss", 1'b0, fv, h, ph, 1'b0);
        run_txn("post_rst_set_field", 1'b1, fv, h, ph, 1'b0);

`ifdef EXECUTOR_STATS_EN
        check("stat_post_rst_hit", 256'(hit_cnt_o), 256'(m_hit));
        check("stat_post_rst_miss", 256'(miss_cnt_o), 256'(m_miss));
        check("stat_post_rst_drop", 256'(drop_cnt_o), 256'(m_drop));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
